// File: rtl/music_player.sv
// Score sequencer and square-wave tone generator driven by an external sheet ROM.
// Define MUSIC_PLAYER_LOOP_EN to repeat the score until stop instead of a single pass.
module music_player #(
  parameter int TICK_CYCLES = 6250000,
  parameter int SONG_LEN    = 49
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        stop,
  input  logic [19:0] note,
  input  logic [4:0]  duration,
  output logic [9:0]  number,
  output logic        speaker,
  output logic        playing,
  output logic        done
);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [9:0]    LAST_IDX  = 10'(SONG_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SOUND} state_t;

  state_t        r_state, w_state_n;
  logic [9:0]    r_number, w_number_n;
  logic          r_speaker, w_speaker_n;
  logic          r_done, w_done_n;
  logic [19:0]   r_note_q, w_note_n;
  logic [19:0]   r_tone_cnt, w_tone_n;
  logic [TW-1:0] r_tick_cnt, w_tick_n;
  logic [4:0]    r_ticks_left, w_left_n;
  logic          w_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_number     <= '0;
      r_speaker    <= 1'b0;
      r_done       <= 1'b0;
      r_note_q     <= '0;
      r_tone_cnt   <= '0;
      r_tick_cnt   <= '0;
      r_ticks_left <= '0;
    end else begin
      r_state      <= w_state_n;
      r_number     <= w_number_n;
      r_speaker    <= w_speaker_n;
      r_done       <= w_done_n;
      r_note_q     <= w_note_n;
      r_tone_cnt   <= w_tone_n;
      r_tick_cnt   <= w_tick_n;
      r_ticks_left <= w_left_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_number_n  = r_number;
    w_speaker_n = r_speaker;
    w_done_n    = 1'b0;
    w_note_n    = r_note_q;
    w_tone_n    = r_tone_cnt;
    w_tick_n    = r_tick_cnt;
    w_left_n    = r_ticks_left;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        w_number_n  = '0;
        w_speaker_n = 1'b0;
        if (play) w_state_n = FETCH;
      end
      FETCH: begin
        w_note_n    = note;
        w_tone_n    = '0;
        w_tick_n    = '0;
        w_left_n    = duration;
        w_speaker_n = 1'b0;
        if (duration == 5'd0) w_advance = 1'b1;
        else                  w_state_n = SOUND;
      end
      SOUND: begin
        // Half-period counter; notes of 0 or 1 are rests.
        if (r_note_q > 20'd1) begin
          if (r_tone_cnt == r_note_q - 20'd1) begin
            w_tone_n    = '0;
            w_speaker_n = ~r_speaker;
          end else begin
            w_tone_n = r_tone_cnt + 20'd1;
          end
        end else begin
          w_speaker_n = 1'b0;
        end
        if (r_tick_cnt == TICK_LAST) begin
          w_tick_n = '0;
          w_left_n = r_ticks_left - 5'd1;
          if (r_ticks_left == 5'd1) w_advance = 1'b1;
        end else begin
          w_tick_n = r_tick_cnt + TW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
    // Entry end: the next FETCH always starts with a silent speaker.
    if (w_advance) begin
      w_speaker_n = 1'b0;
      if (r_number < LAST_IDX) begin
        w_number_n = r_number + 10'd1;
        w_state_n  = FETCH;
      end else begin
        w_number_n = '0;
        w_done_n   = 1'b1;
`ifdef MUSIC_PLAYER_LOOP_EN
        w_state_n  = FETCH;
`else
        w_state_n  = IDLE;
`endif
      end
    end
    if (stop) begin
      w_state_n   = IDLE;
      w_number_n  = '0;
      w_speaker_n = 1'b0;
      w_done_n    = 1'b0;
    end
  end

  assign number  = r_number;
  assign speaker = r_speaker;
  assign done    = r_done;
  assign playing = (r_state != IDLE);
endmodule
